// File: rtl/fifo_drain_arbiter.sv
// Round-robin read scheduler that drains NUM_FIFOS fixed-latency FIFOs into one registered stream,
// bursting on one FIFO, tagging each read with its source and checking returns against the tags.
module fifo_drain_arbiter #(
  parameter int NUM_FIFOS    = 4,
  parameter int WIDTH        = 16,
  parameter int READ_LATENCY = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FIFOS-1:0]         fifoEmpties,
  output logic [NUM_FIFOS-1:0]         readRequests,
  input  logic [NUM_FIFOS*WIDTH-1:0]   fifoDatas,
  input  logic [NUM_FIFOS-1:0]         fifoDataValids,
  input  logic                         slowDown,
  output logic [WIDTH-1:0]             dataOut,
  output logic                         dataOutValid,
  output logic [$clog2(NUM_FIFOS)-1:0] dataOutSource,
  output logic                         protocolError
);
  localparam int SRC_W = $clog2(NUM_FIFOS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic             valid;
    logic             drop;
    logic [SRC_W-1:0] src;
  } tag_t;

  state_t           state, stateNext;
  logic [SRC_W-1:0] pointer, pointerNext, pointerInc, searchBase, cand;
  logic [CNT_W-1:0] burstCount, burstCountNext;
  logic             found, atLimit, burstEnd, grant, errNow;
  logic [NUM_FIFOS-1:0] expectMask;
  tag_t             tagPipe [READ_LATENCY];
  tag_t             tagOut;

  function automatic logic [SRC_W-1:0] wrapIndex(input logic [SRC_W-1:0] base,
                                                 input int unsigned offset);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= 32'(NUM_FIFOS)) sum = sum - 32'(NUM_FIFOS);
    return SRC_W'(sum);
  endfunction

  assign pointerInc = (pointer == SRC_W'(NUM_FIFOS - 1)) ? '0 : pointer + SRC_W'(1);
  assign atLimit    = (state == BURST) && (burstCount == CNT_W'(MAX_BURST));
  // At the burst limit the search starts past the pointer, so a FIFO that is still
  // non-empty cannot take the next grant ahead of the others.
  assign searchBase = atLimit ? pointerInc : pointer;
  assign burstEnd   = fifoEmpties[pointer] || slowDown || atLimit;
  assign grant      = !rst && !slowDown && found;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (!found && !fifoEmpties[wrapIndex(searchBase, i)]) begin
        found = 1'b1;
        cand  = wrapIndex(searchBase, i);
      end
    end
  end

  always_comb begin
    readRequests = '0;
    if (grant) readRequests[cand] = 1'b1;
  end

  always_comb begin
    stateNext      = state;
    pointerNext    = pointer;
    burstCountNext = burstCount;
    case (state)
      IDLE: begin
        if (grant) begin
          stateNext      = BURST;
          pointerNext    = cand;
          burstCountNext = CNT_W'(1);
        end
      end
      BURST: begin
        if (!burstEnd) begin
          burstCountNext = burstCount + CNT_W'(1);
        end else if (grant) begin
          pointerNext    = cand;
          burstCountNext = CNT_W'(1);
        end else begin
          stateNext      = IDLE;
          pointerNext    = pointerInc;
          burstCountNext = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pointer    <= '0;
      burstCount <= '0;
    end else begin
      state      <= stateNext;
      pointer    <= pointerNext;
      burstCount <= burstCountNext;
    end
  end

  // On reset, live tags become drop markers so stale returns are absorbed silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagPipe[0] <= '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++)
        tagPipe[i] <= '{valid: 1'b0, drop: tagPipe[i-1].valid | tagPipe[i-1].drop,
                        src: tagPipe[i-1].src};
    end else begin
      tagPipe[0] <= '{valid: grant, drop: 1'b0, src: cand};
      for (int unsigned i = 1; i < READ_LATENCY; i++)
        tagPipe[i] <= tagPipe[i-1];
    end
  end

  assign tagOut = tagPipe[READ_LATENCY-1];

  always_comb begin
    expectMask = '0;
    if (tagOut.valid || tagOut.drop) expectMask[tagOut.src] = 1'b1;
    errNow = (tagOut.valid && !fifoDataValids[tagOut.src]) || (|(fifoDataValids & ~expectMask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOutValid  <= 1'b0;
      dataOutSource <= '0;
      protocolError <= 1'b0;
    end else begin
      dataOutValid <= tagOut.valid;
      if (tagOut.valid) dataOutSource <= tagOut.src;
      if (errNow) protocolError <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tagOut.valid) dataOut <= fifoDatas[WIDTH*tagOut.src +: WIDTH];
  end

endmodule
